// File: rtl/tl_d_pkg.sv
// Shared TileLink D-channel definitions: opcodes, arbiter states and beat-count helpers.
package tl_d_pkg;

    localparam int unsigned TL_OPCODE_W = 3;
    localparam int unsigned TL_PARAM_W  = 2;

    typedef enum logic [TL_OPCODE_W-1:0] {
        TL_D_ACCESS_ACK      = 3'd0,
        TL_D_ACCESS_ACK_DATA = 3'd1,
        TL_D_HINT_ACK        = 3'd2,
        TL_D_GRANT           = 3'd4,
        TL_D_GRANT_DATA      = 3'd5,
        TL_D_RELEASE_ACK     = 3'd6
    } tl_d_opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } arb_state_e;

    function automatic logic has_data(input logic [TL_OPCODE_W-1:0] opcode);
        return (opcode == TL_OPCODE_W'(TL_D_ACCESS_ACK_DATA)) ||
               (opcode == TL_OPCODE_W'(TL_D_GRANT_DATA));
    endfunction

    // Beats in a message: data responses span 2^size bytes, at least one beat.
    function automatic int unsigned num_beats(input logic [TL_OPCODE_W-1:0] opcode,
                                              input logic [7:0]             size,
                                              input int unsigned            beat_bytes);
        int unsigned bytes;
        int unsigned beats;
        bytes = 32'd1 << size;
        beats = (beat_bytes == 0) ? 32'd1 : bytes / beat_bytes;
        if (!has_data(opcode) || beats == 0) begin
            beats = 32'd1;
        end
        return beats;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping mod N.
module tl_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [PTR_W-1:0] idx_c,
    output logic             any_c
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PTR_W'((32'(ptr) + k) % N);
            if (!found && valid[cand]) begin
                found          = 1'b1;
                grant_c[cand]  = 1'b1;
                idx_c          = cand;
            end
        end
        any_c = found;
    end

endmodule

// File: rtl/tl_d_channel_arbiter.sv
// Round-robin merge of N_IN TileLink D channels onto one, keeping multi-beat data
// responses atomic and the grant stable while a beat is stalled.
module tl_d_channel_arbiter
    import tl_d_pkg::*;
#(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned BEAT_BYTES = 4,
    parameter int unsigned SIZE_W     = 3,
    parameter int unsigned SOURCE_W   = 4,
    parameter int unsigned SINK_W     = 1,
    parameter int unsigned USER_W     = 1,
    localparam int unsigned DATA_W    = 8 * BEAT_BYTES
) (
    input  logic                         clock,
    input  logic                         reset_n,

    input  logic [N_IN-1:0]              in_valid,
    output logic [N_IN-1:0]              in_ready,
    input  logic [N_IN*TL_OPCODE_W-1:0]  in_opcode,
    input  logic [N_IN*TL_PARAM_W-1:0]   in_param,
    input  logic [N_IN*SIZE_W-1:0]       in_size,
    input  logic [N_IN*SOURCE_W-1:0]     in_source,
    input  logic [N_IN*SINK_W-1:0]       in_sink,
    input  logic [N_IN-1:0]              in_denied,
    input  logic [N_IN-1:0]              in_corrupt,
    input  logic [N_IN*DATA_W-1:0]       in_data,
    input  logic [N_IN*USER_W-1:0]       in_user,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TL_OPCODE_W-1:0]       out_opcode,
    output logic [TL_PARAM_W-1:0]        out_param,
    output logic [SIZE_W-1:0]            out_size,
    output logic [SOURCE_W-1:0]          out_source,
    output logic [SINK_W-1:0]            out_sink,
    output logic                         out_denied,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_corrupt,
    output logic [USER_W-1:0]            out_user,
    output logic [N_IN-1:0]              out_grant
);

    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned BL_W  = SIZE_W + 1;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BL_W-1:0]   beats_left_q, beats_left_d;
    logic [PTR_W-1:0]  owner_q, owner_d;

    logic [N_IN-1:0]   pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;

    logic [PTR_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic                   fire;
    logic [BL_W-1:0]        sel_beats;
    logic [PTR_W-1:0]       ptr_after_sel;
    logic [TL_OPCODE_W-1:0] sel_opcode;
    logic [TL_PARAM_W-1:0]  sel_param;
    logic [SIZE_W-1:0]      sel_size;
    logic [SOURCE_W-1:0]    sel_source;
    logic [SINK_W-1:0]      sel_sink;
    logic                   sel_denied;
    logic                   sel_corrupt;
    logic [DATA_W-1:0]      sel_data;
    logic [USER_W-1:0]      sel_user;

    tl_rr_pick #(
        .N (N_IN)
    ) u_pick (
        .valid   (in_valid),
        .ptr     (rr_ptr_q),
        .grant_c (pick_grant),
        .idx_c   (pick_idx),
        .any_c   (pick_any)
    );

    // Only IDLE arbitrates; HOLD and BURST stay locked on the recorded owner.
    always_comb begin
        sel_idx       = (state_q == ST_IDLE) ? pick_idx : owner_q;
        sel_valid     = (state_q == ST_IDLE) ? pick_any : in_valid[owner_q];
        fire          = reset_n && sel_valid && out_ready;
        ptr_after_sel = (sel_idx == PTR_W'(N_IN - 1)) ? '0 : sel_idx + PTR_W'(1);
    end

    always_comb begin
        sel_opcode  = '0;
        sel_param   = '0;
        sel_size    = '0;
        sel_source  = '0;
        sel_sink    = '0;
        sel_denied  = 1'b0;
        sel_corrupt = 1'b0;
        sel_data    = '0;
        sel_user    = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (PTR_W'(i) == sel_idx) begin
                sel_opcode  = in_opcode[TL_OPCODE_W*i +: TL_OPCODE_W];
                sel_param   = in_param[TL_PARAM_W*i +: TL_PARAM_W];
                sel_size    = in_size[SIZE_W*i +: SIZE_W];
                sel_source  = in_source[SOURCE_W*i +: SOURCE_W];
                sel_sink    = in_sink[SINK_W*i +: SINK_W];
                sel_denied  = in_denied[i];
                sel_corrupt = in_corrupt[i];
                sel_data    = in_data[DATA_W*i +: DATA_W];
                sel_user    = in_user[USER_W*i +: USER_W];
            end
        end
        sel_beats = BL_W'(num_beats(sel_opcode, 8'(sel_size), BEAT_BYTES));
    end

    // Outputs are forced to zero while reset_n is low and when nothing is offered.
    always_comb begin
        out_valid   = reset_n && sel_valid;
        out_opcode  = out_valid ? sel_opcode  : '0;
        out_param   = out_valid ? sel_param   : '0;
        out_size    = out_valid ? sel_size    : '0;
        out_source  = out_valid ? sel_source  : '0;
        out_sink    = out_valid ? sel_sink    : '0;
        out_denied  = out_valid ? sel_denied  : 1'b0;
        out_corrupt = out_valid ? sel_corrupt : 1'b0;
        out_data    = out_valid ? sel_data    : '0;
        out_user    = out_valid ? sel_user    : '0;
        in_ready    = fire ? (N_IN'(1) << sel_idx) : '0;
        if (!reset_n) begin
            out_grant = '0;
        end else if (state_q == ST_IDLE) begin
            out_grant = pick_grant;
        end else begin
            out_grant = N_IN'(1) << owner_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        beats_left_d = beats_left_q;
        owner_d      = owner_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (fire) begin
                    if (sel_beats > BL_W'(1)) begin
                        state_d      = ST_BURST;
                        beats_left_d = sel_beats - BL_W'(1);
                        owner_d      = sel_idx;
                    end else begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ptr_after_sel;
                    end
                end else if (state_q == ST_IDLE && sel_valid) begin
                    state_d = ST_HOLD;
                    owner_d = sel_idx;
                end
            end
            ST_BURST: begin
                if (fire) begin
                    beats_left_d = beats_left_q - BL_W'(1);
                    if (beats_left_q == BL_W'(1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = ptr_after_sel;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            beats_left_q <= '0;
            owner_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= beats_left_d;
            owner_q      <= owner_d;
        end
    end

endmodule

// File: tb/tb_tl_d_channel_arbiter.sv
// Directed and randomized checks of tl_d_channel_arbiter against a message-level reference model.
module tb_tl_d_channel_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  prm;
        logic [2:0]  sz;
        logic [3:0]  src;
        logic        snk;
        logic        den;
        logic        cor;
        logic [31:0] dat;
        logic        usr;
        logic        last;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N*3-1:0]  in_opcode;
    logic [N*2-1:0]  in_param;
    logic [N*3-1:0]  in_size;
    logic [N*4-1:0]  in_source;
    logic [N-1:0]    in_sink;
    logic [N-1:0]    in_denied;
    logic [N-1:0]    in_corrupt;
    logic [N*32-1:0] in_data;
    logic [N-1:0]    in_user;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_opcode;
    logic [1:0]    out_param;
    logic [2:0]    out_size;
    logic [3:0]    out_source;
    logic [0:0]    out_sink;
    logic          out_denied;
    logic [31:0]   out_data;
    logic          out_corrupt;
    logic [0:0]    out_user;
    logic [N-1:0]  out_grant;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    beat_t       q [N][$];
    beat_t       b;
    beat_t       hb;
    bit          held [N];
    logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [2:0]  op;
    logic [2:0]  sz;
    int          nb;
    int          cnt [N];
    int          e;
    int          w;
    int          m_owner;
    int          m_ptr;
    int          cyc;
    logic        exp_valid;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;

    tl_d_channel_arbiter #(
        .N_IN(N), .BEAT_BYTES(4), .SIZE_W(3), .SOURCE_W(4), .SINK_W(1), .USER_W(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_param(in_param), .in_size(in_size), .in_source(in_source),
        .in_sink(in_sink), .in_denied(in_denied), .in_corrupt(in_corrupt),
        .in_data(in_data), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_param(out_param), .out_size(out_size), .out_source(out_source),
        .out_sink(out_sink), .out_denied(out_denied), .out_data(out_data),
        .out_corrupt(out_corrupt), .out_user(out_user), .out_grant(out_grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic v, input logic [N-1:0] rdy,
                           input logic [N-1:0] gnt);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_ready"}, 64'(in_ready), 64'(rdy));
        check({tag, "_grant"}, 64'(out_grant), 64'(gnt));
    endtask

    task automatic put(input int i, input logic [2:0] o, input logic [2:0] s, input logic [31:0] d);
        in_valid[i]          = 1'b1;
        in_opcode[3*i +: 3]  = o;
        in_param[2*i +: 2]   = 2'(i);
        in_size[3*i +: 3]    = s;
        in_source[4*i +: 4]  = 4'(i + 4);
        in_sink[i]           = 1'b1;
        in_denied[i]         = 1'b0;
        in_corrupt[i]        = 1'b0;
        in_data[32*i +: 32]  = d;
        in_user[i]           = 1'(i);
    endtask

    task automatic drive_beat(input int i, input beat_t bt);
        in_opcode[3*i +: 3]  = bt.op;
        in_param[2*i +: 2]   = bt.prm;
        in_size[3*i +: 3]    = bt.sz;
        in_source[4*i +: 4]  = bt.src;
        in_sink[i]           = bt.snk;
        in_denied[i]         = bt.den;
        in_corrupt[i]        = bt.cor;
        in_data[32*i +: 32]  = bt.dat;
        in_user[i]           = bt.usr;
    endtask

    function automatic logic [31:0] bdata(input int i, input int bn);
        return 32'hD000_0000 | 32'(i << 8) | 32'(bn);
    endfunction

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; out_ready = 1'b0; in_valid = '0;
        in_opcode = '0; in_param = '0; in_size = '0; in_source = '0; in_sink = '0;
        in_denied = '0; in_corrupt = '0; in_data = '0; in_user = '0;
        next_cycle();

        // Reset forces every output to zero even with all inputs valid.
        for (int i = 0; i < N; i++) put(i, 3'd1, 3'd2, bdata(i, 9));
        out_ready = 1'b1;
        @(negedge clock);
        chk_ctl("reset", 1'b0, 4'b0000, 4'b0000);
        check("reset_data", 64'(out_data), 64'(0));
        check("reset_source", 64'(out_source), 64'(0));
        next_cycle();
        reset_n = 1'b1; in_valid = '0;

        // Single AccessAck on input 2, accepted in the same cycle.
        put(2, 3'd0, 3'd0, 32'hA2A2_0001);
        @(negedge clock);
        chk_ctl("single2", 1'b1, 4'b0100, 4'b0100);
        check("single2_data", 64'(out_data), 64'h0000_0000_A2A2_0001);
        check("single2_source", 64'(out_source), 64'(6));
        next_cycle();
        in_valid[2] = 1'b0;
        // rr_ptr is now 3: input 3 beats input 0.
        put(0, 3'd0, 3'd0, 32'h1);
        put(3, 3'd0, 3'd0, 32'h3);
        @(negedge clock);
        chk_ctl("ptr3", 1'b1, 4'b1000, 4'b1000);
        next_cycle();
        in_valid = '0;

        // Two 4-beat AccessAckData bursts from inputs 0 and 1: no interleave.
        cnt[0] = 0; cnt[1] = 0;
        put(0, 3'd1, 3'd4, bdata(0, 0));
        put(1, 3'd1, 3'd4, bdata(1, 0));
        for (int c = 0; c < 8; c++) begin
            e = (c < 4) ? 0 : 1;
            @(negedge clock);
            check("burst_grant", 64'(out_grant), 64'(4'(1 << e)));
            check("burst_data", 64'(out_data), 64'(bdata(e, cnt[e])));
            next_cycle();
            cnt[e]++;
            if (cnt[e] == 4) in_valid[e] = 1'b0;
            else put(e, 3'd1, 3'd4, bdata(e, cnt[e]));
        end
        @(negedge clock);
        chk_ctl("burst_done", 1'b0, 4'b0000, 4'b0000);
        next_cycle();

        // Stall on input 1 (HOLD); input 0 arriving later must not steal the grant.
        out_ready = 1'b0;
        put(1, 3'd0, 3'd0, 32'h11);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk_ctl("hold", 1'b1, 4'b0000, 4'b0010);
            next_cycle();
        end
        put(0, 3'd0, 3'd0, 32'h10);
        @(negedge clock);
        chk_ctl("hold_new0", 1'b1, 4'b0000, 4'b0010);
        next_cycle();
        out_ready = 1'b1;
        @(negedge clock);
        chk_ctl("hold_accept1", 1'b1, 4'b0010, 4'b0010);
        check("hold_data1", 64'(out_data), 64'h11);
        next_cycle();
        in_valid[1] = 1'b0;
        @(negedge clock);
        chk_ctl("after_hold0", 1'b1, 4'b0001, 4'b0001);
        next_cycle();
        in_valid[0] = 1'b0;

        // Burst owner 3 pauses mid-burst while input 0 waits.
        put(3, 3'd5, 3'd4, bdata(3, 0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk_ctl("gap_pre", 1'b1, 4'b1000, 4'b1000);
            next_cycle();
            put(3, 3'd5, 3'd4, bdata(3, c + 1));
        end
        in_valid[3] = 1'b0;
        put(0, 3'd0, 3'd0, 32'h20);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check("gap_valid", 64'(out_valid), 64'(0));
            check("gap_ready", 64'(in_ready), 64'(0));
            next_cycle();
        end
        for (int c = 2; c < 4; c++) begin
            put(3, 3'd5, 3'd4, bdata(3, c));
            @(negedge clock);
            chk_ctl("gap_post", 1'b1, 4'b1000, 4'b1000);
            check("gap_post_data", 64'(out_data), 64'(bdata(3, c)));
            next_cycle();
        end
        in_valid[3] = 1'b0;
        @(negedge clock);
        chk_ctl("gap_then0", 1'b1, 4'b0001, 4'b0001);
        next_cycle();
        in_valid[0] = 1'b0;

        // Reset after beat 2 of 4 abandons the burst; input 0 wins afterwards.
        for (int c = 0; c < 2; c++) begin
            put(1, 3'd1, 3'd4, bdata(1, c));
            @(negedge clock);
            chk_ctl("prerst", 1'b1, 4'b0010, 4'b0010);
            next_cycle();
        end
        put(1, 3'd1, 3'd4, bdata(1, 2));
        put(2, 3'd0, 3'd0, 32'h22);
        reset_n = 1'b0;
        @(negedge clock);
        chk_ctl("midrst", 1'b0, 4'b0000, 4'b0000);
        check("midrst_data", 64'(out_data), 64'(0));
        next_cycle();
        reset_n = 1'b1;
        in_valid[1] = 1'b0;
        put(0, 3'd0, 3'd0, 32'h30);
        @(negedge clock);
        chk_ctl("postrst0", 1'b1, 4'b0001, 4'b0001);
        next_cycle();
        in_valid[0] = 1'b0;
        @(negedge clock);
        chk_ctl("postrst2", 1'b1, 4'b0100, 4'b0100);
        next_cycle();
        in_valid = '0;

        // Randomized traffic against the message-level model.
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            held[i] = 1'b0;
            for (int m = 0; m < 12; m++) begin
                op = ops[$urandom_range(0, 5)];
                if (op == 3'd1 || op == 3'd5) begin
                    sz = 3'($urandom_range(0, 5));
                    nb = ((1 << sz) > 4) ? (1 << sz) / 4 : 1;
                end else begin
                    sz = 3'($urandom_range(0, 7));
                    nb = 1;
                end
                b.op  = op;
                b.prm = 2'($urandom_range(0, 3));
                b.sz  = sz;
                b.src = 4'($urandom_range(0, 15));
                b.snk = 1'($urandom_range(0, 1));
                b.den = 1'($urandom_range(0, 1));
                b.usr = 1'($urandom_range(0, 1));
                for (int k = 0; k < nb; k++) begin
                    b.cor  = 1'($urandom_range(0, 1));
                    b.dat  = $urandom;
                    b.last = (k == nb - 1);
                    q[i].push_back(b);
                end
            end
        end
        m_owner = -1;
        m_ptr   = 0;
        cyc     = 0;
        while (pending() != 0 && cyc < 6000) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0) begin
                    in_valid[i] = 1'b0;
                end else begin
                    if (!held[i]) in_valid[i] = ($urandom_range(0, 9) < 6);
                    drive_beat(i, q[i][0]);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            w = -1;
            if (m_owner >= 0) begin
                w = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && in_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
            end
            exp_valid = (w >= 0) && in_valid[w];
            exp_grant = (w >= 0) ? 4'(1 << w) : 4'b0000;
            exp_ready = (exp_valid && out_ready) ? exp_grant : 4'b0000;
            chk_ctl("rnd", exp_valid, exp_ready, exp_grant);
            if (exp_valid) begin
                hb = q[w][0];
                check("rnd_data", 64'(out_data), 64'(hb.dat));
                check("rnd_user", 64'(out_user), 64'(hb.usr));
                check("rnd_hdr",
                      64'({out_opcode, out_param, out_size, out_source, out_sink, out_denied, out_corrupt}),
                      64'({hb.op, hb.prm, hb.sz, hb.src, hb.snk, hb.den, hb.cor}));
            end
            for (int i = 0; i < N; i++) held[i] = in_valid[i];
            if (exp_valid && out_ready) begin
                held[w] = 1'b0;
                void'(q[w].pop_front());
                if (hb.last) begin
                    m_owner = -1;
                    m_ptr   = (w + 1) % N;
                end else begin
                    m_owner = w;
                end
            end else if (exp_valid && m_owner < 0) begin
                m_owner = w;
            end
            next_cycle();
            cyc++;
        end
        check("rnd_drained", 64'(pending()), 64'(0));
        in_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
